// File: rtl/y2r_pkg.sv
// Shared definitions for the y2r parameter path: address map, shift limits,
// writer FSM states and the shift-exponent clamp used by writer and decoder.
package y2r_pkg;

  localparam int PARA_DW_DEF = 12;

  localparam logic [3:0] A_Y00   = 4'd0;
  localparam logic [3:0] A_Y01   = 4'd1;
  localparam logic [3:0] A_Y02   = 4'd2;
  localparam logic [3:0] A_Y10   = 4'd3;
  localparam logic [3:0] A_Y11   = 4'd4;
  localparam logic [3:0] A_Y12   = 4'd5;
  localparam logic [3:0] A_Y20   = 4'd6;
  localparam logic [3:0] A_Y21   = 4'd7;
  localparam logic [3:0] A_Y22   = 4'd8;
  localparam logic [3:0] A_Y03   = 4'd9;
  localparam logic [3:0] A_Y13   = 4'd10;
  localparam logic [3:0] A_Y23   = 4'd11;
  localparam logic [3:0] A_SHIFT = 4'd12;

  localparam logic [4:0] SHIFT_MIN = 5'd8;
  localparam logic [4:0] SHIFT_MAX = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    COMMIT = 2'd2
  } y2r_state_e;

  // Keeps the exponent inside the range the datapath rounding logic supports.
  function automatic logic [4:0] shift_clamp(input logic [4:0] raw);
    logic [4:0] res;
    if (raw < SHIFT_MIN) begin
      res = SHIFT_MIN;
    end else if (raw > SHIFT_MAX) begin
      res = SHIFT_MAX;
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/y2r_para_bank.sv
// One parameter slot: a shadow register written by the word stream and an
// active register that copies the shadow only when commit is enabled.
module y2r_para_bank #(
  parameter int             W       = 12,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         commit_en_i,
  output logic [W-1:0] act_o
);

  logic [W-1:0] shadow_q;
  logic [W-1:0] shadow_d;
  logic [W-1:0] act_q;
  logic [W-1:0] act_d;

  always_comb begin
    shadow_d = shadow_q;
    act_d    = act_q;
    if (wr_en_i) begin
      shadow_d = wr_data_i;
    end
    if (commit_en_i) begin
      act_d = shadow_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= RST_VAL;
      act_q    <= RST_VAL;
    end else begin
      shadow_q <= shadow_d;
      act_q    <= act_d;
    end
  end

  assign act_o = act_q;

endmodule

// File: rtl/y2r_para_load.sv
// y2r parameter writer: collects a parameter set into shadow registers and
// commits it atomically to the active outputs at the next frame boundary.
module y2r_para_load
  import y2r_pkg::*;
#(
  parameter int PARA_DW = PARA_DW_DEF,
  parameter int OFS_DW  = PARA_DW + 8
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_addr,
  input  logic [OFS_DW-1:0] wr_data,
  input  logic              wr_last,
  input  logic              frame_start,
  output logic [PARA_DW-1:0] y2r_00,
  output logic [PARA_DW-1:0] y2r_01,
  output logic [PARA_DW-1:0] y2r_02,
  output logic [PARA_DW-1:0] y2r_10,
  output logic [PARA_DW-1:0] y2r_11,
  output logic [PARA_DW-1:0] y2r_12,
  output logic [PARA_DW-1:0] y2r_20,
  output logic [PARA_DW-1:0] y2r_21,
  output logic [PARA_DW-1:0] y2r_22,
  output logic [OFS_DW-1:0] y2r_03,
  output logic [OFS_DW-1:0] y2r_13,
  output logic [OFS_DW-1:0] y2r_23,
  output logic [4:0]        shift_bit,
  output logic              para_vld,
  output logic              para_upd,
  output logic              wr_err
);

  y2r_state_e state_q;
  y2r_state_e state_d;

  logic xfer;
  logic commit_en;
  logic unmapped;

  logic [8:0] coef_we;
  logic [2:0] ofs_we;
  logic       shift_we;

  logic [PARA_DW-1:0] coef_act [9];
  logic [OFS_DW-1:0]  ofs_act  [3];
  logic [4:0]         shift_act;

  logic para_vld_q, para_vld_d;
  logic para_upd_q, para_upd_d;
  logic wr_err_q,   wr_err_d;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A last word landing together with frame_start only closes the set;
  // the commit waits for a later frame boundary seen while in PEND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer && wr_last) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (frame_start) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ready  = (state_q == IDLE);
    commit_en = (state_q == COMMIT);
  end

  assign xfer     = wr_valid && wr_ready;
  assign unmapped = wr_addr > A_SHIFT;
  assign shift_we = xfer && (wr_addr == A_SHIFT);

  for (genvar k = 0; k < 9; k++) begin : g_coef
    assign coef_we[k] = xfer && (wr_addr == A_Y00 + 4'(k));

    y2r_para_bank #(
      .W       (PARA_DW),
      .RST_VAL ('0)
    ) u_bank (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .wr_en_i     (coef_we[k]),
      .wr_data_i   (wr_data[PARA_DW-1:0]),
      .commit_en_i (commit_en),
      .act_o       (coef_act[k])
    );
  end

  for (genvar k = 0; k < 3; k++) begin : g_ofs
    assign ofs_we[k] = xfer && (wr_addr == A_Y03 + 4'(k));

    y2r_para_bank #(
      .W       (OFS_DW),
      .RST_VAL ('0)
    ) u_bank (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .wr_en_i     (ofs_we[k]),
      .wr_data_i   (wr_data),
      .commit_en_i (commit_en),
      .act_o       (ofs_act[k])
    );
  end

  // The exponent is clamped on the way into the shadow so the active value
  // is always legal for the decoder.
  y2r_para_bank #(
    .W       (5),
    .RST_VAL (SHIFT_MIN)
  ) u_shift_bank (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .wr_en_i     (shift_we),
    .wr_data_i   (shift_clamp(wr_data[4:0])),
    .commit_en_i (commit_en),
    .act_o       (shift_act)
  );

  always_comb begin
    para_upd_d = commit_en;
    para_vld_d = para_vld_q || commit_en;
    wr_err_d   = wr_err_q || (xfer && unmapped);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      para_upd_q <= 1'b0;
      para_vld_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      para_upd_q <= para_upd_d;
      para_vld_q <= para_vld_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign y2r_00    = coef_act[0];
  assign y2r_01    = coef_act[1];
  assign y2r_02    = coef_act[2];
  assign y2r_10    = coef_act[3];
  assign y2r_11    = coef_act[4];
  assign y2r_12    = coef_act[5];
  assign y2r_20    = coef_act[6];
  assign y2r_21    = coef_act[7];
  assign y2r_22    = coef_act[8];
  assign y2r_03    = ofs_act[0];
  assign y2r_13    = ofs_act[1];
  assign y2r_23    = ofs_act[2];
  assign shift_bit = shift_act;
  assign para_vld  = para_vld_q;
  assign para_upd  = para_upd_q;
  assign wr_err    = wr_err_q;

endmodule
